// File: rtl/ack_timeout_ctrl.sv
// ack_timeout_ctrl
// Tracks the ACK response window after a local transmission that expects an
// ACK. The deadline is derived from SIFS, the ACK preamble length, the ACK
// symbol count and a fixed margin. The block then waits for the PHY to start
// receiving (rx_start) and, once reception has begun, for the FCS verdict
// (rx_end). Exactly one outcome pulse is produced per accepted tx_done,
// unless the wait is cancelled or reset.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   tx_done           : end of local TX; need_ack/ack_ht_flag/ack_rate_mcs/
//                       sifs_us are sampled with it
//   n_sym_q_ht/_mcs   : registered ACK format, drives an external lookup
//   n_sym             : lookup result (ACK symbol count), used in LOOKUP
//   rx_start, rx_end  : PHY header accepted / FCS evaluation complete
//   rx_fcs_ok, rx_is_ack : reception verdict, valid with rx_end
//   cancel            : abort a pending wait without an outcome pulse
//   busy              : high whenever the FSM is not idle
//   ack_ok/ack_fail/ack_timeout : single-cycle outcome pulses
//   deadline_us       : latched deadline in microseconds (debug)
module ack_timeout_ctrl #(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned SLACK_US   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_done,
  input  logic       need_ack,
  input  logic       ack_ht_flag,
  input  logic [3:0] ack_rate_mcs,
  output logic       n_sym_q_ht,
  output logic [3:0] n_sym_q_mcs,
  input  logic [2:0] n_sym,
  input  logic [7:0] sifs_us,
  input  logic       rx_start,
  input  logic       rx_end,
  input  logic       rx_fcs_ok,
  input  logic       rx_is_ack,
  input  logic       cancel,
  output logic       busy,
  output logic       ack_ok,
  output logic       ack_fail,
  output logic       ack_timeout,
  output logic [8:0] deadline_us
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOOKUP     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_END   = 2'd3
  } state_e;

  localparam logic [7:0] PRESC_LAST = 8'(CLK_PER_US - 1);
  localparam logic [6:0] GUARD_US   = 7'd64;

  state_e     state_q;
  logic       busy_q;
  logic       ack_ok_q;
  logic       ack_fail_q;
  logic       ack_timeout_q;
  logic       ht_q;
  logic [3:0] mcs_q;
  logic [7:0] sifs_q;
  logic [8:0] deadline_q;
  logic [7:0] presc_q;
  logic [8:0] us_cnt_q;
  logic [6:0] guard_q;

  logic        presc_wrap;
  logic [7:0]  presc_d;
  logic [9:0]  us_cnt_d;
  logic [6:0]  guard_d;
  logic [31:0] dl_sum;
  logic [8:0]  dl_sat;

  // The prescaler is shared: it times microseconds for the deadline while
  // waiting for rx_start, and for the reception guard while waiting for rx_end.
  assign presc_wrap = (presc_q == PRESC_LAST);
  assign presc_d    = presc_wrap ? 8'd0 : presc_q + 8'd1;
  assign us_cnt_d   = {1'b0, us_cnt_q} + 10'd1;
  assign guard_d    = guard_q + 7'd1;

  // Deadline = SIFS + preamble (20 us legacy, 36 us HT-mixed) + 4 us/symbol
  // + margin, computed wide and clamped so a large margin cannot wrap.
  assign dl_sum = 32'(sifs_q) + (ht_q ? 32'd36 : 32'd20)
                + {27'd0, n_sym, 2'b00} + 32'(SLACK_US);
  assign dl_sat = (dl_sum > 32'd511) ? 9'd511 : dl_sum[8:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      ack_ok_q      <= 1'b0;
      ack_fail_q    <= 1'b0;
      ack_timeout_q <= 1'b0;
      ht_q          <= 1'b0;
      mcs_q         <= 4'd0;
      sifs_q        <= 8'd0;
      deadline_q    <= 9'd0;
      presc_q       <= 8'd0;
      us_cnt_q      <= 9'd0;
      guard_q       <= 7'd0;
    end else begin
      ack_ok_q      <= 1'b0;
      ack_fail_q    <= 1'b0;
      ack_timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_done && need_ack) begin
            ht_q     <= ack_ht_flag;
            mcs_q    <= ack_rate_mcs;
            sifs_q   <= sifs_us;
            presc_q  <= 8'd0;
            us_cnt_q <= 9'd0;
            guard_q  <= 7'd0;
            busy_q   <= 1'b1;
            state_q  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            deadline_q <= dl_sat;
            presc_q    <= presc_d;
            if (presc_wrap) us_cnt_q <= us_cnt_d[8:0];
            state_q    <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (rx_start) begin
            // us_cnt freezes; the rx_start cycle is tick 0 of the guard
            // window, so the prescaler resumes at 1 (CLK_PER_US >= 2).
            presc_q <= 8'd1;
            guard_q <= 7'd0;
            state_q <= WAIT_END;
          end else begin
            presc_q <= presc_d;
            if (presc_wrap) begin
              us_cnt_q <= us_cnt_d[8:0];
              // Fire as the count reaches the deadline so the pulse lands
              // exactly deadline_us microseconds after the LOOKUP cycle.
              if (us_cnt_d >= {1'b0, deadline_q}) begin
                ack_timeout_q <= 1'b1;
                busy_q        <= 1'b0;
                state_q       <= IDLE;
              end
            end
          end
        end
        WAIT_END: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (rx_end) begin
            // An rx_end coinciding with guard expiry still reports the verdict.
            ack_ok_q   <= rx_fcs_ok & rx_is_ack;
            ack_fail_q <= ~(rx_fcs_ok & rx_is_ack);
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            presc_q <= presc_d;
            if (presc_wrap) begin
              guard_q <= guard_d;
              if (guard_d == GUARD_US) begin
                ack_timeout_q <= 1'b1;
                busy_q        <= 1'b0;
                state_q       <= IDLE;
              end
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign ack_ok      = ack_ok_q;
  assign ack_fail    = ack_fail_q;
  assign ack_timeout = ack_timeout_q;
  assign n_sym_q_ht  = ht_q;
  assign n_sym_q_mcs = mcs_q;
  assign deadline_us = deadline_q;

endmodule

// File: tb/tb_ack_timeout_ctrl.sv
// Directed bench for ack_timeout_ctrl. Stimulus pushes the expected outcome
// (kind, cycle, deadline) into a scoreboard queue; a negedge monitor pops and
// compares whenever an outcome pulse appears. A second instance with a large
// margin exercises deadline saturation.
module tb_ack_timeout_ctrl;

  localparam int CLK = 4;

  logic       clk;
  logic       rst;
  logic       tx_done, need_ack, ack_ht_flag;
  logic [3:0] ack_rate_mcs;
  logic [2:0] n_sym;
  logic [7:0] sifs_us;
  logic       rx_start, rx_end, rx_fcs_ok, rx_is_ack, cancel;

  logic       n_sym_q_ht, busy, ack_ok, ack_fail, ack_timeout;
  logic [3:0] n_sym_q_mcs;
  logic [8:0] deadline_us;

  logic       ht2, b2, ok2, fail2, to2;
  logic [3:0] mcs2;
  logic [8:0] dl2;

  ack_timeout_ctrl #(.CLK_PER_US(CLK), .SLACK_US(4)) dut (
    .clk(clk), .rst(rst), .tx_done(tx_done), .need_ack(need_ack),
    .ack_ht_flag(ack_ht_flag), .ack_rate_mcs(ack_rate_mcs),
    .n_sym_q_ht(n_sym_q_ht), .n_sym_q_mcs(n_sym_q_mcs), .n_sym(n_sym),
    .sifs_us(sifs_us), .rx_start(rx_start), .rx_end(rx_end),
    .rx_fcs_ok(rx_fcs_ok), .rx_is_ack(rx_is_ack), .cancel(cancel),
    .busy(busy), .ack_ok(ack_ok), .ack_fail(ack_fail),
    .ack_timeout(ack_timeout), .deadline_us(deadline_us)
  );

  ack_timeout_ctrl #(.CLK_PER_US(CLK), .SLACK_US(250)) dut_sat (
    .clk(clk), .rst(rst), .tx_done(tx_done), .need_ack(need_ack),
    .ack_ht_flag(ack_ht_flag), .ack_rate_mcs(ack_rate_mcs),
    .n_sym_q_ht(ht2), .n_sym_q_mcs(mcs2), .n_sym(n_sym),
    .sifs_us(sifs_us), .rx_start(rx_start), .rx_end(rx_end),
    .rx_fcs_ok(rx_fcs_ok), .rx_is_ack(rx_is_ack), .cancel(cancel),
    .busy(b2), .ack_ok(ok2), .ack_fail(fail2),
    .ack_timeout(to2), .deadline_us(dl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;   // 1 = ack_ok, 2 = ack_fail, 3 = ack_timeout
    int cyc;
    int dl;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one outcome pulse is one transaction.
  int   m_kind, m_cnt;
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst && (ack_ok || ack_fail || ack_timeout)) begin
      m_kind = ack_ok ? 1 : (ack_fail ? 2 : 3);
      m_cnt  = int'(ack_ok) + int'(ack_fail) + int'(ack_timeout);
      check("pulse_onehot", m_cnt, 1);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", m_kind, cyc);
      end else begin
        m_e = sb.pop_front();
        check("outcome_kind", m_kind, m_e.kind);
        check("outcome_cycle", cyc, m_e.cyc);
        check("outcome_deadline", int'(deadline_us), m_e.dl);
        check("busy_at_outcome", int'(busy), 0);
        $display("[TB] outcome kind=%0d cycle=%0d deadline=%0d", m_kind, cyc, deadline_us);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit na, input bit ht, input logic [3:0] mcs,
                       input logic [2:0] ns, input logic [7:0] sifs, output int l);
    tx_done = 1'b1; need_ack = na; ack_ht_flag = ht;
    ack_rate_mcs = mcs; n_sym = ns; sifs_us = sifs;
    l = cyc + 1;
    step();
    tx_done = 1'b0; need_ack = 1'b0;
  endtask

  task automatic pulse_rx_start();
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
  endtask

  task automatic pulse_rx_end(input bit fok, input bit isack);
    rx_end = 1'b1; rx_fcs_ok = fok; rx_is_ack = isack;
    step();
    rx_end = 1'b0; rx_fcs_ok = 1'b0; rx_is_ack = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      step();
      n++;
    end
    check("outcome_arrived", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, s;
    rst = 1'b1; tx_done = 0; need_ack = 0; ack_ht_flag = 0; ack_rate_mcs = 0;
    n_sym = 3'd1; sifs_us = 0; rx_start = 0; rx_end = 0; rx_fcs_ok = 0;
    rx_is_ack = 0; cancel = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'(ack_ok | ack_fail | ack_timeout), 0);
    check("rst_ht", int'(n_sym_q_ht), 0);
    check("rst_mcs", int'(n_sym_q_mcs), 0);
    check("rst_deadline", int'(deadline_us), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Legacy 6 Mbps, no rx_start: timeout 64 us after LOOKUP; tx_done while busy ignored
    issue(1, 0, 4'b1011, 3'd6, 8'd16, l);
    check("t1_mcs", int'(n_sym_q_mcs), 11);
    check("t1_ht", int'(n_sym_q_ht), 0);
    check("t1_busy", int'(busy), 1);
    sb.push_back('{3, l + 64 * CLK, 64});
    step();
    check("t1_deadline", int'(deadline_us), 64);
    wait_cyc(l + 10);
    tx_done = 1'b1; need_ack = 1'b1; sifs_us = 8'd200;
    step();
    tx_done = 1'b0; need_ack = 1'b0;
    drain(64 * CLK + 20);

    // HT MCS7: rx_start at 30 us, repeated rx_start ignored, good ACK
    issue(1, 1, 4'd7, 3'd1, 8'd16, l);
    s = l + 30 * CLK;
    wait_cyc(s);
    pulse_rx_start();
    wait_cyc(s + 3);
    pulse_rx_start();
    wait_cyc(s + 6);
    sb.push_back('{1, s + 7, 60});
    pulse_rx_end(1, 1);
    drain(20);

    // rx_start in the cycle the deadline is reached wins; bad FCS -> fail
    issue(1, 0, 4'b1011, 3'd6, 8'd16, l);
    s = l + 64 * CLK - 1;
    wait_cyc(s);
    sb.push_back('{2, s + 5, 64});
    pulse_rx_start();
    wait_cyc(s + 4);
    pulse_rx_end(0, 1);
    drain(20);

    // rx_start without rx_end: guard timeout 64 us after rx_start
    issue(1, 1, 4'd7, 3'd6, 8'd16, l);
    s = l + 42;
    wait_cyc(s);
    sb.push_back('{3, s + 64 * CLK, 80});
    pulse_rx_start();
    drain(64 * CLK + 20);

    // Idle: tx_done without need_ack, stray rx_start/rx_end ignored
    tx_done = 1'b1; need_ack = 1'b0; rx_start = 1'b1;
    step();
    tx_done = 1'b0; rx_start = 1'b0;
    check("idle_noack_busy", int'(busy), 0);
    pulse_rx_end(1, 1);
    check("idle_rxend_busy", int'(busy), 0);
    repeat (3) step();

    // cancel during WAIT_END together with rx_end: cancel wins, no pulse
    issue(1, 0, 4'd3, 3'd1, 8'd10, l);
    wait_cyc(l + 20);
    pulse_rx_start();
    wait_cyc(l + 25);
    cancel = 1'b1; rx_end = 1'b1; rx_fcs_ok = 1'b1; rx_is_ack = 1'b1;
    step();
    cancel = 1'b0; rx_end = 1'b0; rx_fcs_ok = 1'b0; rx_is_ack = 1'b0;
    check("cancel_busy", int'(busy), 0);
    repeat (5) step();

    // Reset asserted during WAIT_END: immediate abort, no pulse
    issue(1, 1, 4'd5, 3'd2, 8'd10, l);
    wait_cyc(l + 20);
    pulse_rx_start();
    wait_cyc(l + 25);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_deadline", int'(deadline_us), 0);
    check("midrst_ht", int'(n_sym_q_ht), 0);
    check("midrst_mcs", int'(n_sym_q_mcs), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First tx_done after reset honored; deadline clamp on the wide-margin instance
    issue(1, 1, 4'd7, 3'd6, 8'd255, l);
    check("post_rst_busy", int'(busy), 1);
    check("sat_busy", int'(b2), 1);
    check("sat_ht", int'(ht2), 1);
    check("sat_mcs", int'(mcs2), 7);
    step();
    check("t8_deadline", int'(deadline_us), 319);
    check("sat_deadline", int'(dl2), 511);
    sb.push_back('{3, l + 319 * CLK, 319});
    drain(319 * CLK + 20);
    check("sat_still_busy", int'(b2), 1);
    check("sat_no_pulse", int'(ok2 | fail2 | to2), 0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("sat_cancel_busy", int'(b2), 0);

    // tx_done without need_ack after the aborts keeps busy low
    tx_done = 1'b1; need_ack = 1'b0;
    step();
    tx_done = 1'b0;
    check("final_noack_busy", int'(busy), 0);
    step();
    check("final_noack_busy2", int'(busy), 0);
    repeat (3) step();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
